load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage of the RV32I core: accepts one load or store per request from the execute stage, runs a ready/valid transaction on the data-memory bus, and handles byte-lane steering, byte enables and load sign/zero extension. The extended load result (`loadData`) feeds the data-memory input of the writeback select mux. Wait states, bus timeout, illegal `funct3` and (optionally) misalignment are reported with a one-cycle completion pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait cycles allowed in REQUEST before abort; 0 disables the timeout. Counter is 16 bits wide.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `startAccess`  in  1  request; sampled only in IDLE
- `isStore`  in  1  1 = store, 0 = load
- `funct3`  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- `address`  in  32  byte address
- `storeData`  in  32  rs2 value
- `busy`  out  1  state != IDLE
- `accessDone`  out  1  one-cycle completion pulse
- `loadData`  out  32  extended load result; held until the next completion
- `accessFault`  out  1  valid with `accessDone`: illegal `funct3` or timeout
- `misaligned`  out  1  valid with `accessDone`
- `memReq`  out  1  bus request
- `memWe`  out  1  write enable
- `memAddr`  out  32  word-aligned address ({address[31:2],2'b00})
- `memWData`  out  32  lane-replicated write data
- `memByteEn`  out  4  byte enables
- `memRData`  in  32  read data, valid when `memReady`=1
- `memReady`  in  1  bus completes the transfer this cycle

## Operation
- FSM states: IDLE, REQUEST, DONE.
- IDLE: on `startAccess`=1, register `isStore`, `funct3`, address, byte enables and write data. Illegal `funct3` (011, 110, 111; stores with funct3[2]=1) or a misaligned fault goes to DONE with no bus cycle. Otherwise go to REQUEST.
- REQUEST: `memReq`=1, and `memAddr`/`memWe`/`memByteEn`/`memWData` stay stable. On `memReady`=1, capture the load result and go to DONE. Each cycle with `memReady`=0 increments the wait counter. When the counter equals `TIMEOUT_CYCLES` (non-zero), go to DONE with `accessFault`=1 and `loadData`=0.
- DONE: `accessDone`=1 for one cycle, then IDLE. `accessFault` and `misaligned` are valid only in this cycle and 0 otherwise.
- Byte lane: lane = address[1:0].
- Loads: LB/LBU select `memRData[8*lane+7 -: 8]`, sign- or zero-extended. LH/LHU select the halfword at address[1]. LW passes the full word.
- Stores:
  - SB: byte replicated ×4, `memByteEn` = 4'b0001<<lane.
  - SH: halfword replicated ×2, `memByteEn` = 4'b0011 or 4'b1100.
  - SW: `memByteEn` = 4'b1111.
- Loads drive `memByteEn` = 4'b1111. `loadData` is unchanged by store completions.
- `startAccess` while `busy` is ignored.

## Timing
- Reset (asynchronous): state IDLE; every output, including `memReq`, is 0 immediately. This applies even mid-transaction; the pending access is dropped and never reported.
- Start sampled at edge N. REQUEST occupies cycles N+1 onward. `memReady` in cycle N+1+k gives `accessDone` in cycle N+2+k. Zero-wait latency is 2 cycles from start to `accessDone`.
- Fault without a bus cycle: `accessDone` in cycle N+1.
- Back-to-back: the next `startAccess` can be accepted in the cycle after DONE.
- Timeout: abort after exactly `TIMEOUT_CYCLES` wait cycles. `memReq` drops on entry to DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - halfword with address[0]=1, or word with address[1:0]≠0, completes via DONE with `misaligned`=1, `accessFault`=0 and no bus transaction;
  - `loadData` is unchanged.
- Undefined:
  - `misaligned` is tied 0;
  - halfword accesses ignore address[0], and word accesses ignore address[1:0];
  - the access proceeds normally.

## Test plan
- LB address 0x0000_1003, `memRData`=0x80FF_1234, `memReady` in the first REQUEST cycle -> `memAddr`=0x0000_1000, `accessDone` 2 cycles after start, `loadData`=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH address 0x0000_2002, `storeData`=0x1234_ABCD -> `memWe`=1, `memByteEn`=4'b1100, `memWData`=0xABCD_ABCD, `memAddr`=0x0000_2000.
- LW with `memReady` held low 3 cycles -> `memReq` high 4 cycles, signals stable throughout, `accessDone` 5 cycles after start, `loadData`=`memRData`.
- `TIMEOUT_CYCLES`=4, `memReady` never asserted -> `accessDone` with `accessFault`=1 and `loadData`=0.
- LW at 0x0000_1002 -> with `LSU_MISALIGN_TRAP_EN`: `misaligned`=1, no `memReq`, `accessDone` 1 cycle after start. Without it: `memAddr`=0x0000_1000 and normal load. Also cover `funct3`=011 -> `accessFault`=1, no `memReq`.
- `reset` asserted mid-REQUEST -> `memReq`, `busy` and `loadData` go to 0 asynchronously, with no `accessDone`; a new request after reset release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load/store per request over a ready/valid data bus,
// with lane steering, byte enables and load extension. Optional trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startAccess,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        accessDone,
  output logic [31:0] loadData,
  output logic        accessFault,
  output logic        misaligned,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memByteEn,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        is_store_q;
  logic [2:0]  f3_q;
  logic [29:0] word_q;
  logic [1:0]  lane_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [15:0] wait_cnt;
  logic        fault_q;
  logic [31:0] load_q;

  logic        illegal;
  logic        misal_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [15:0] next_cnt;

  // Stores only have SB/SH/SW; loads additionally allow the unsigned forms.
  always_comb begin
    illegal = 1'b0;
    if (funct3 == 3'b011) illegal = 1'b1;
    else if (isStore && funct3[2]) illegal = 1'b1;
    else if (!isStore && funct3[2:1] == 2'b11) illegal = 1'b1;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_q;
  always_comb begin
    misal_c = 1'b0;
    if (funct3[1:0] == 2'b01 && address[0]) misal_c = 1'b1;
    if (funct3[1:0] == 2'b10 && address[1:0] != 2'b00) misal_c = 1'b1;
  end
  assign misaligned = (state == S_DONE) && misal_q;
`else
  assign misal_c    = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = storeData;
    if (isStore) begin
      case (funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << address[1:0];
          wdata_c = {4{storeData[7:0]}};
        end
        2'b01: begin
          be_c    = address[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{storeData[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = storeData;
        end
      endcase
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = memRData[7:0];
      2'd1:    byte_sel = memRData[15:8];
      2'd2:    byte_sel = memRData[23:16];
      default: byte_sel = memRData[31:24];
    endcase
    half_sel = lane_q[1] ? memRData[31:16] : memRData[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = memRData;
    endcase
  end

  assign next_cnt = wait_cnt + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      is_store_q <= 1'b0;
      f3_q       <= 3'd0;
      word_q     <= 30'd0;
      lane_q     <= 2'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      wait_cnt   <= 16'd0;
      fault_q    <= 1'b0;
      load_q     <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (startAccess) begin
          is_store_q <= isStore;
          f3_q       <= funct3;
          word_q     <= address[31:2];
          lane_q     <= address[1:0];
          be_q       <= be_c;
          wdata_q    <= wdata_c;
          wait_cnt   <= 16'd0;
          fault_q    <= illegal;
`ifdef LSU_MISALIGN_TRAP_EN
          misal_q    <= misal_c && !illegal;
`endif
          state      <= (illegal || misal_c) ? S_DONE : S_REQ;
        end
        S_REQ: begin
          if (memReady) begin
            if (!is_store_q) load_q <= load_ext;
            state <= S_DONE;
          end else if (TIMEOUT_CYCLES != 0 && next_cnt == TIMEOUT_CYCLES[15:0]) begin
            // Timeout aborts the transfer and reports a cleared result.
            fault_q <= 1'b1;
            load_q  <= 32'd0;
            state   <= S_DONE;
          end else begin
            wait_cnt <= next_cnt;
          end
        end
        S_DONE: begin
          fault_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          misal_q <= 1'b0;
`endif
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign accessDone  = (state == S_DONE);
  assign accessFault = (state == S_DONE) && fault_q;
  assign loadData    = load_q;
  assign memReq      = (state == S_REQ);
  assign memWe       = (state == S_REQ) && is_store_q;
  assign memAddr     = {word_q, 2'b00};
  assign memWData    = wdata_q;
  assign memByteEn   = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with TIMEOUT_CYCLES=4.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startAccess = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        busy, accessDone, accessFault, misaligned, memReq, memWe;
  logic [31:0] loadData, memAddr, memWData;
  logic [3:0]  memByteEn;
  logic [31:0] memRData = 32'd0;
  logic        memReady = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .startAccess(startAccess), .isStore(isStore),
    .funct3(funct3), .address(address), .storeData(storeData), .busy(busy),
    .accessDone(accessDone), .loadData(loadData), .accessFault(accessFault),
    .misaligned(misaligned), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .memByteEn(memByteEn), .memRData(memRData), .memReady(memReady)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    isStore = st; funct3 = f3; address = a; storeData = d; startAccess = 1'b1;
    step();
    startAccess = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", accessDone, 0);
    chk("rst_req", memReq, 0);
    chk("rst_load", loadData, 0);
    chk("rst_addr", memAddr, 0);
    step(); step();
    reset = 1'b0;
    step();

    // LB, zero-wait
    memRData = 32'h80FF_1234; memReady = 1'b1;
    start(1'b0, 3'b000, 32'h0000_1003, 32'd0);
    chk("lb_req", memReq, 1);
    chk("lb_addr", memAddr, 32'h0000_1000);
    chk("lb_be", memByteEn, 4'b1111);
    chk("lb_we", memWe, 0);
    chk("lb_early_done", accessDone, 0);
    step();
    chk("lb_done", accessDone, 1);
    chk("lb_data", loadData, 32'hFFFF_FF80);
    chk("lb_fault", accessFault, 0);
    chk("lb_busy", busy, 1);
    step();
    chk("lb_idle_done", accessDone, 0);
    chk("lb_idle_busy", busy, 0);

    // LBU back-to-back
    start(1'b0, 3'b100, 32'h0000_1003, 32'd0);
    step();
    chk("lbu_done", accessDone, 1);
    chk("lbu_data", loadData, 32'h0000_0080);
    step();

    // LH upper half, LHU lower half
    start(1'b0, 3'b001, 32'h0000_1002, 32'd0);
    step();
    chk("lh_data", loadData, 32'hFFFF_80FF);
    step();
    start(1'b0, 3'b101, 32'h0000_1000, 32'd0);
    step();
    chk("lhu_data", loadData, 32'h0000_1234);
    step();

    // SH upper half
    start(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    chk("sh_we", memWe, 1);
    chk("sh_be", memByteEn, 4'b1100);
    chk("sh_wdata", memWData, 32'hABCD_ABCD);
    chk("sh_addr", memAddr, 32'h0000_2000);
    step();
    chk("sh_done", accessDone, 1);
    chk("sh_load_kept", loadData, 32'h0000_1234);
    step();

    // SB lane 1
    start(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00CD);
    chk("sb_be", memByteEn, 4'b0010);
    chk("sb_wdata", memWData, 32'hCDCD_CDCD);
    step(); step();

    // LW with 3 wait states; a start pulse while busy must be ignored
    memReady = 1'b0; memRData = 32'hDEAD_BEEF;
    start(1'b0, 3'b010, 32'h0000_3000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("lw_wait_req", memReq, 1);
      chk("lw_wait_addr", memAddr, 32'h0000_3000);
      chk("lw_wait_done", accessDone, 0);
      startAccess = (i < 3); address = 32'h0000_5554;
      if (i == 3) memReady = 1'b1;
      step();
    end
    startAccess = 1'b0;
    chk("lw_wait_fin", accessDone, 1);
    chk("lw_wait_data", loadData, 32'hDEAD_BEEF);
    chk("lw_wait_req_off", memReq, 0);
    step();
    chk("lw_ignored_start", busy, 0);

    // Timeout after 4 wait cycles
    memReady = 1'b0;
    start(1'b0, 3'b010, 32'h0000_3000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", memReq, 1);
      chk("to_done_early", accessDone, 0);
      step();
    end
    chk("to_done", accessDone, 1);
    chk("to_fault", accessFault, 1);
    chk("to_data", loadData, 0);
    chk("to_req_off", memReq, 0);
    step();
    chk("to_fault_clr", accessFault, 0);

    // LW at 0x1002
    memReady = 1'b1; memRData = 32'h1122_3344;
    start(1'b0, 3'b010, 32'h0000_1002, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_done", accessDone, 1);
    chk("mis_flag", misaligned, 1);
    chk("mis_fault", accessFault, 0);
    chk("mis_req", memReq, 0);
    chk("mis_data", loadData, 0);
`else
    chk("mis_req", memReq, 1);
    chk("mis_addr", memAddr, 32'h0000_1000);
    step();
    chk("mis_done", accessDone, 1);
    chk("mis_flag", misaligned, 0);
    chk("mis_data", loadData, 32'h1122_3344);
`endif
    step();

    // Illegal funct3: load 011, store 100
    start(1'b0, 3'b011, 32'h0000_1000, 32'd0);
    chk("ill_ld_done", accessDone, 1);
    chk("ill_ld_fault", accessFault, 1);
    chk("ill_ld_req", memReq, 0);
    step();
    start(1'b1, 3'b100, 32'h0000_1000, 32'd0);
    chk("ill_st_fault", accessFault, 1);
    chk("ill_st_req", memReq, 0);
    step();

    // Load a known value, then reset mid-REQUEST
    memRData = 32'hCAFE_F00D;
    start(1'b0, 3'b010, 32'h0000_4000, 32'd0);
    step();
    chk("pre_rst_data", loadData, 32'hCAFE_F00D);
    step();
    memReady = 1'b0;
    start(1'b0, 3'b010, 32'h0000_4000, 32'd0);
    chk("mid_req", memReq, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", memReq, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", loadData, 0);
    step();
    chk("arst_no_done", accessDone, 0);
    reset = 1'b0;
    step();
    chk("post_rst_no_done", accessDone, 0);

    // Fresh request after reset release
    memReady = 1'b1; memRData = 32'h80FF_1234;
    start(1'b0, 3'b000, 32'h0000_1003, 32'd0);
    chk("post_req", memReq, 1);
    step();
    chk("post_done", accessDone, 1);
    chk("post_data", loadData, 32'hFFFF_FF80);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
